// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs and EX/MEM register outputs of the execute stage
interface ex_stage_if #(
  parameter int DW = 32
);
  // pipeline control
  logic          stall;
  logic          flush;
  // ID/EX register contents
  logic          in_valid;
  logic [3:0]    alu_op;
  logic          alu_src;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] imm;
  logic [4:0]    rd;
  logic          regwrite;
  logic          memread;
  logic          memwrite;
  // forwarding
  logic [1:0]    forwardA;
  logic [1:0]    forwardB;
  logic [DW-1:0] mem_wb_data;
  // EX/MEM register
  logic          ex_mem_valid;
  logic [DW-1:0] ex_mem_alu_result;
  logic [DW-1:0] ex_mem_store_data;
  logic [4:0]    ex_mem_rd;
  logic          ex_mem_regwrite;
  logic          ex_mem_memread;
  logic          ex_mem_memwrite;
  logic          ex_mem_zero;
  logic          ex_mem_sign;
  logic          ex_mem_carry;

  modport master (
    output stall, flush, in_valid, alu_op, alu_src, rs_data, rt_data, imm,
           rd, regwrite, memread, memwrite, forwardA, forwardB, mem_wb_data,
    input  ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_zero,
           ex_mem_sign, ex_mem_carry
  );

  modport slave (
    input  stall, flush, in_valid, alu_op, alu_src, rs_data, rt_data, imm,
           rd, regwrite, memread, memwrite, forwardA, forwardB, mem_wb_data,
    output ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_zero,
           ex_mem_sign, ex_mem_carry
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU and EX/MEM pipeline register
module ex_stage #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] store_data;
    logic [4:0]    rd;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          zero;
    logic          sign;
    logic          carry;
  } ex_mem_t;

  ex_mem_t ex_mem_q;
  ex_mem_t ex_mem_d;

  logic [DW-1:0] op_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] op_b;
  logic [4:0]    shamt;
  logic [DW:0]   sum_add;
  logic [DW:0]   sum_sub;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          slt_lt;

  // operand selection; the EX/MEM path uses the registered (pre-edge) result
  always_comb begin
    op_a = bus.rs_data;
    case (bus.forwardA)
      2'b01:   op_a = bus.mem_wb_data;
      2'b10:   op_a = ex_mem_q.alu_result;
      default: op_a = bus.rs_data;
    endcase
    fwd_b = bus.rt_data;
    case (bus.forwardB)
      2'b01:   fwd_b = bus.mem_wb_data;
      2'b10:   fwd_b = ex_mem_q.alu_result;
      default: fwd_b = bus.rt_data;
    endcase
    op_b  = bus.alu_src ? bus.imm : fwd_b;
    shamt = op_b[4:0];
  end

  // ALU; carry only meaningful for ADD/SUB
  always_comb begin
    sum_add   = {1'b0, op_a} + {1'b0, op_b};
    sum_sub   = {1'b0, op_a} + {1'b0, ~op_b} + {{DW{1'b0}}, 1'b1};
    slt_lt    = $signed(op_a) < $signed(op_b);
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_op)
      4'h0: begin alu_res = sum_add[DW-1:0]; alu_carry = sum_add[DW]; end
      4'h1: begin alu_res = sum_sub[DW-1:0]; alu_carry = sum_sub[DW]; end
      4'h2: alu_res = op_a & op_b;
      4'h3: alu_res = op_a | op_b;
      4'h4: alu_res = op_a ^ op_b;
      4'h5: alu_res = ~op_a;
      4'h6: alu_res = op_a << shamt;
      4'h7: alu_res = op_a >> shamt;
      4'h8: alu_res = $unsigned($signed(op_a) >>> shamt);
      4'h9: alu_res = (~op_a) + {{(DW-1){1'b0}}, 1'b1};
      4'hA: alu_res = {{(DW-1){1'b0}}, slt_lt};
      4'hB: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // next EX/MEM contents: flush beats stall beats load; invalid input loads a bubble
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (bus.flush) begin
      ex_mem_d = '0;
    end else if (bus.stall) begin
      ex_mem_d = ex_mem_q;
    end else if (!bus.in_valid) begin
      ex_mem_d = '0;
    end else begin
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.alu_result = alu_res;
      ex_mem_d.store_data = fwd_b;
      ex_mem_d.rd         = bus.rd;
      ex_mem_d.regwrite   = bus.regwrite;
      ex_mem_d.memread    = bus.memread;
      ex_mem_d.memwrite   = bus.memwrite;
      ex_mem_d.zero       = (alu_res == '0);
      ex_mem_d.sign       = alu_res[DW-1];
      ex_mem_d.carry      = alu_carry;
    end
  end

  // EX/MEM register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  assign bus.ex_mem_valid      = ex_mem_q.valid;
  assign bus.ex_mem_alu_result = ex_mem_q.alu_result;
  assign bus.ex_mem_store_data = ex_mem_q.store_data;
  assign bus.ex_mem_rd         = ex_mem_q.rd;
  assign bus.ex_mem_regwrite   = ex_mem_q.regwrite;
  assign bus.ex_mem_memread    = ex_mem_q.memread;
  assign bus.ex_mem_memwrite   = ex_mem_q.memwrite;
  assign bus.ex_mem_zero       = ex_mem_q.zero;
  assign bus.ex_mem_sign       = ex_mem_q.sign;
  assign bus.ex_mem_carry      = ex_mem_q.carry;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with a reference model
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        zero;
    logic        sign;
    logic        carry;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if #(.DW(32)) bus ();
  ex_stage #(.DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  obs_t        exp_q[$];
  string       name_q[$];
  logic [32:0] want_q[$];
  obs_t        m;
  int          total = 0;
  int          bad = 0;
  bit          stim_done = 1'b0;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'b01) return bus.mem_wb_data;
    if (sel == 2'b10) return m.res;
    return reg_v;
  endfunction

  // what the EX/MEM register should hold after the coming edge
  function automatic obs_t model_next();
    obs_t n;
    logic [31:0] a, rtv, b, r;
    longint unsigned s;
    int sh;
    bit c;
    n = '0;
    if (rst || bus.flush) return n;
    if (bus.stall) return m;
    if (!bus.in_valid) return n;
    a   = pick(bus.forwardA, bus.rs_data);
    rtv = pick(bus.forwardB, bus.rt_data);
    b   = bus.alu_src ? bus.imm : rtv;
    sh  = int'(b % 32);
    c   = 1'b0;
    case (bus.alu_op)
      4'd0: begin s = longint'(a) + longint'(b); r = s[31:0]; c = s[32]; end
      4'd1: begin r = a - b; c = (a >= b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: r = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd9: r = 32'd0 - a;
      4'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: r = b;
      default: r = 32'd0;
    endcase
    n.valid = 1'b1;
    n.res   = r;
    n.st    = rtv;
    n.rd    = bus.rd;
    n.rw    = bus.regwrite;
    n.mr    = bus.memread;
    n.mw    = bus.memwrite;
    n.zero  = (r == 32'd0);
    n.sign  = r[31];
    n.carry = c;
    return n;
  endfunction

  task automatic tick(input string nm, input bit has_w, input logic [31:0] w);
    obs_t n;
    n = model_next();
    exp_q.push_back(n);
    name_q.push_back(nm);
    want_q.push_back({has_w, w});
    m = n;
    @(negedge clk);
  endtask

  task automatic clr();
    rst = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.alu_op = 4'd0; bus.alu_src = 1'b0;
    bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0;
    bus.rd = 5'd0; bus.regwrite = 1'b0; bus.memread = 1'b0; bus.memwrite = 1'b0;
    bus.forwardA = 2'b00; bus.forwardB = 2'b00; bus.mem_wb_data = '0;
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt);
    clr();
    bus.in_valid = 1'b1; bus.alu_op = o; bus.rs_data = rs; bus.rt_data = rt;
    bus.rd = 5'd1; bus.regwrite = 1'b1;
  endtask

  task automatic rand_inputs();
    bus.in_valid = ($urandom_range(0, 3) != 0);
    bus.alu_op = 4'($urandom_range(0, 15));
    bus.alu_src = 1'($urandom);
    bus.rs_data = $urandom;
    bus.rt_data = ($urandom_range(0, 7) == 0) ? bus.rs_data : $urandom;
    bus.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
    bus.rd = 5'($urandom);
    bus.regwrite = 1'($urandom); bus.memread = 1'($urandom); bus.memwrite = 1'($urandom);
    bus.forwardA = 2'($urandom); bus.forwardB = 2'($urandom);
    bus.mem_wb_data = $urandom;
  endtask

  // monitor: compare each registered output against the scoreboard after every edge
  initial begin
    obs_t act, e;
    string nm;
    logic [32:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        w = want_q.pop_front();
        act = {bus.ex_mem_valid, bus.ex_mem_alu_result, bus.ex_mem_store_data, bus.ex_mem_rd,
               bus.ex_mem_regwrite, bus.ex_mem_memread, bus.ex_mem_memwrite,
               bus.ex_mem_zero, bus.ex_mem_sign, bus.ex_mem_carry};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
        if (w[32]) begin
          total++;
          if (act.res !== w[31:0]) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", nm, act.res, w[31:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    m = '0;
    clr();
    rst = 1'b1;
    tick("reset0", 1, 32'd0);
    tick("reset1", 1, 32'd0);
    clr();
    tick("bubble", 1, 32'd0);

    op(4'd0, 32'h7FFF_FFFF, 32'd1);   tick("add_ovf", 1, 32'h8000_0000);
    op(4'd1, 32'd5, 32'd5);           tick("sub_eq", 1, 32'd0);
    op(4'd1, 32'd0, 32'd1);           tick("sub_borrow", 1, 32'hFFFF_FFFF);

    op(4'd0, 32'd3, 32'd4);           tick("dep_first", 1, 32'd7);
    op(4'd0, 32'd0, 32'd10); bus.forwardA = 2'b10;
    tick("dep_fwd_exmem", 1, 32'd17);
    op(4'd0, 32'd1, 32'd0); bus.forwardB = 2'b01; bus.mem_wb_data = 32'h100;
    tick("dep_fwd_memwb", 1, 32'h101);

    op(4'd8, 32'h8000_0000, 32'd0); bus.alu_src = 1'b1; bus.imm = 32'h24;
    tick("sra", 1, 32'hF800_0000);
    op(4'd6, 32'h8000_0000, 32'd0); bus.alu_src = 1'b1; bus.imm = 32'h24;
    tick("sll", 1, 32'd0);
    op(4'd10, 32'hFFFF_FFFF, 32'd1);  tick("slt", 1, 32'd1);
    op(4'd9, 32'd1, 32'd0);           tick("comp", 1, 32'hFFFF_FFFF);

    op(4'd0, 32'd2, 32'd3); bus.memwrite = 1'b1; tick("stall_load", 1, 32'd5);
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); bus.stall = 1'b1; bus.flush = 1'b0;
      tick("stall_hold", 1, 32'd5);
    end
    op(4'd0, 32'd9, 32'd9); bus.memwrite = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
    tick("stall_flush", 1, 32'd0);

    op(4'd3, 32'hF0, 32'h0F);         tick("pre_rst_load", 1, 32'hFF);
    op(4'd0, 32'd1, 32'd1); bus.stall = 1'b1; tick("pre_rst_stall", 1, 32'hFF);
    op(4'd0, 32'd1, 32'd1); bus.stall = 1'b1; rst = 1'b1; tick("rst_in_stall", 1, 32'd0);
    op(4'd4, 32'hFF, 32'h0F);         tick("post_rst_load", 1, 32'hF0);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      bus.stall = ($urandom_range(0, 5) == 0);
      tick("random", 0, 32'd0);
    end
    clr();
    tick("drain", 1, 32'd0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
